// File: rtl/flo288_iter.sv
// flo288_iter: walks a 288-bit mask from the highest set bit downwards,
// presenting one bit index per cycle on a valid/ready output stream.
//
// Handshake: an index transfers in any cycle where o_valid=1 and o_ready=1.
// While o_valid=1 and o_ready=0, o_idx, o_valid and o_last stay unchanged.
// o_valid never depends combinationally on o_ready.
module flo288_iter #(
  parameter logic [8:0] NONE = 9'd511
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [287:0] mask_i,
  input  logic         abort,
  input  logic         o_ready,
  output logic         o_valid,
  output logic [8:0]   o_idx,
  output logic         o_last,
  output logic         busy,
  output logic         done,
  output logic [8:0]   cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [287:0]   rem, rem_n;
  logic           o_valid_n;
  logic [8:0]     o_idx_n;
  logic           done_n;
  logic [8:0]     cnt_n;

  // Find-last-one split into two 144-bit halves.
  logic [7:0]     lo_idx, hi_idx;
  logic           lo_any, hi_any;
  logic [8:0]     flo_idx;
  logic           rem_zero;
  logic           hs;

  // Highest set bit in each half; ascending scan so the top-most hit wins.
  always_comb begin
    lo_idx = 8'd0;
    hi_idx = 8'd0;
    lo_any = 1'b0;
    hi_any = 1'b0;
    for (int i = 0; i < 144; i++) begin
      if (rem[i]) begin
        lo_idx = 8'(i);
        lo_any = 1'b1;
      end
      if (rem[144 + i]) begin
        hi_idx = 8'(i);
        hi_any = 1'b1;
      end
    end
  end

  // Upper half takes precedence; rem_zero marks an exhausted mask.
  always_comb begin
    flo_idx  = hi_any ? (9'd144 + {1'b0, hi_idx}) : {1'b0, lo_idx};
    rem_zero = ~(lo_any | hi_any);
    hs       = o_valid & o_ready;
  end

  // Next-state and datapath updates for the three-state walker.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    o_valid_n = o_valid;
    o_idx_n   = o_idx;
    done_n    = 1'b0;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        // abort outranks ld, and has nothing else to do while idle
        if (ld && !abort) begin
          rem_n   = mask_i;
          cnt_n   = 9'd0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          rem_n     = '0;
          o_valid_n = 1'b0;
          o_idx_n   = NONE;
          state_n   = IDLE;
        end else if (rem_zero) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          o_idx_n          = flo_idx;
          rem_n[flo_idx]   = 1'b0;
          o_valid_n        = 1'b1;
          state_n          = EMIT;
        end
      end
      EMIT: begin
        // a handshake coinciding with abort is dropped, cnt untouched
        if (abort) begin
          rem_n     = '0;
          o_valid_n = 1'b0;
          o_idx_n   = NONE;
          state_n   = IDLE;
        end else if (hs) begin
          cnt_n = cnt + 9'd1;
          if (!rem_zero) begin
            o_idx_n        = flo_idx;
            rem_n[flo_idx] = 1'b0;
          end else begin
            o_valid_n = 1'b0;
            o_idx_n   = NONE;
            done_n    = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: begin
        rem_n     = '0;
        o_valid_n = 1'b0;
        o_idx_n   = NONE;
        state_n   = IDLE;
      end
    endcase
  end

  // State and datapath registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      o_valid <= 1'b0;
      o_idx   <= NONE;
      done    <= 1'b0;
      cnt     <= 9'd0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      o_valid <= o_valid_n;
      o_idx   <= o_idx_n;
      done    <= done_n;
      cnt     <= cnt_n;
    end
  end

  // Status flags derived from registered state.
  always_comb begin
    busy   = (state != IDLE);
    o_last = o_valid & rem_zero;
  end

endmodule

// File: tb/tb_flo288_iter.sv
// Directed bench for flo288_iter. Cycle k is the period after the k-th
// rising edge following ld; inputs are driven and outputs sampled 1ns after
// each rising edge.
module tb_flo288_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [287:0] mask_i;
  logic         abort;
  logic         o_ready;
  logic         o_valid;
  logic [8:0]   o_idx;
  logic         o_last;
  logic         busy;
  logic         done;
  logic [8:0]   cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  localparam logic [8:0] NONE = 9'd511;

  flo288_iter #(.NONE(NONE)) dut (
    .clk(clk), .rst(rst), .ld(ld), .mask_i(mask_i), .abort(abort),
    .o_ready(o_ready), .o_valid(o_valid), .o_idx(o_idx), .o_last(o_last),
    .busy(busy), .done(done), .cnt(cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, required $finish before 2ms");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".valid"}, 32'(o_valid), 32'd0);
    check({tag, ".idx"},   32'(o_idx),   32'(NONE));
    check({tag, ".last"},  32'(o_last),  32'd0);
    check({tag, ".done"},  32'(done),    32'd0);
    check({tag, ".busy"},  32'(busy),    32'd0);
    check({tag, ".cnt"},   32'(cnt),     32'd0);
  endtask

  task automatic start(input logic [287:0] m, input logic rdy);
    mask_i  = m;
    ld      = 1'b1;
    o_ready = rdy;
    tick();           // now in cycle 1
    ld      = 1'b0;
    mask_i  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [287:0] m;

  initial begin
    rst = 1'b1; ld = 1'b0; mask_i = '0; abort = 1'b0; o_ready = 1'b0;
    do_reset();
    check_idle_reset("reset");

    // bits {287,144,0}, continuous ready
    m = '0; m[287] = 1'b1; m[144] = 1'b1; m[0] = 1'b0; m[0] = 1'b1;
    start(m, 1'b1);
    check("a.c1.busy", 32'(busy), 32'd1);
    check("a.c1.valid", 32'(o_valid), 32'd0);
    tick();
    check("a.c2.valid", 32'(o_valid), 32'd1);
    check("a.c2.idx", 32'(o_idx), 32'd287);
    check("a.c2.last", 32'(o_last), 32'd0);
    tick();
    check("a.c3.idx", 32'(o_idx), 32'd144);
    check("a.c3.last", 32'(o_last), 32'd0);
    check("a.c3.cnt", 32'(cnt), 32'd1);
    tick();
    check("a.c4.idx", 32'(o_idx), 32'd0);
    check("a.c4.last", 32'(o_last), 32'd1);
    check("a.c4.done", 32'(done), 32'd0);
    tick();
    check("a.c5.done", 32'(done), 32'd1);
    check("a.c5.valid", 32'(o_valid), 32'd0);
    check("a.c5.idx", 32'(o_idx), 32'(NONE));
    check("a.c5.busy", 32'(busy), 32'd0);
    check("a.c5.cnt", 32'(cnt), 32'd3);
    tick();
    check("a.c6.done", 32'(done), 32'd0);

    // empty mask
    start('0, 1'b1);
    check("b.c1.busy", 32'(busy), 32'd1);
    check("b.c1.valid", 32'(o_valid), 32'd0);
    tick();
    check("b.c2.done", 32'(done), 32'd1);
    check("b.c2.busy", 32'(busy), 32'd0);
    check("b.c2.valid", 32'(o_valid), 32'd0);
    check("b.c2.cnt", 32'(cnt), 32'd0);
    tick();
    check("b.c3.done", 32'(done), 32'd0);

    // bits {5,3}, consumer stalls in cycles 2-4
    m = '0; m[5] = 1'b1; m[3] = 1'b1;
    start(m, 1'b0);
    tick();
    for (int c = 2; c <= 4; c++) begin
      check($sformatf("c.c%0d.valid", c), 32'(o_valid), 32'd1);
      check($sformatf("c.c%0d.idx", c), 32'(o_idx), 32'd5);
      check($sformatf("c.c%0d.last", c), 32'(o_last), 32'd0);
      tick();
    end
    o_ready = 1'b1;
    check("c.c5.idx", 32'(o_idx), 32'd5);
    check("c.c5.cnt", 32'(cnt), 32'd0);
    tick();
    check("c.c6.idx", 32'(o_idx), 32'd3);
    check("c.c6.last", 32'(o_last), 32'd1);
    check("c.c6.cnt", 32'(cnt), 32'd1);
    tick();
    check("c.c7.done", 32'(done), 32'd1);
    check("c.c7.cnt", 32'(cnt), 32'd2);
    tick();

    // bits {200,100,50}, abort in cycle 3 together with a handshake
    m = '0; m[200] = 1'b1; m[100] = 1'b1; m[50] = 1'b1;
    start(m, 1'b1);
    tick();
    check("d.c2.idx", 32'(o_idx), 32'd200);
    tick();
    check("d.c3.idx", 32'(o_idx), 32'd100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("d.c4.valid", 32'(o_valid), 32'd0);
    check("d.c4.idx", 32'(o_idx), 32'(NONE));
    check("d.c4.done", 32'(done), 32'd0);
    check("d.c4.cnt", 32'(cnt), 32'd1);
    check("d.c4.busy", 32'(busy), 32'd0);
    tick();
    check("d.c5.done", 32'(done), 32'd0);
    check("d.c5.busy", 32'(busy), 32'd0);

    // abort beats ld while idle
    mask_i = 288'd1; ld = 1'b1; abort = 1'b1;
    tick();
    ld = 1'b0; abort = 1'b0;
    check("e.abort_ld.busy", 32'(busy), 32'd0);
    check("e.abort_ld.cnt", 32'(cnt), 32'd1);

    // ld ignored while busy, accepted in the done cycle
    m = '0; m[2] = 1'b1; m[1] = 1'b1;
    start(m, 1'b1);
    m = '0; m[7] = 1'b1;
    mask_i = m; ld = 1'b1;          // held from cycle 1 onwards
    tick();
    check("f.c2.idx", 32'(o_idx), 32'd2);
    tick();
    check("f.c3.idx", 32'(o_idx), 32'd1);
    check("f.c3.last", 32'(o_last), 32'd1);
    check("f.c3.cnt", 32'(cnt), 32'd1);
    tick();
    check("f.c4.done", 32'(done), 32'd1);
    check("f.c4.busy", 32'(busy), 32'd0);
    check("f.c4.cnt", 32'(cnt), 32'd2);
    tick();                          // ld taken in the done cycle
    ld = 1'b0; mask_i = '0;
    check("f.c5.busy", 32'(busy), 32'd1);
    check("f.c5.cnt", 32'(cnt), 32'd0);
    check("f.c5.valid", 32'(o_valid), 32'd0);
    tick();
    check("f.c6.valid", 32'(o_valid), 32'd1);
    check("f.c6.idx", 32'(o_idx), 32'd7);
    check("f.c6.last", 32'(o_last), 32'd1);
    tick();
    check("f.c7.done", 32'(done), 32'd1);
    check("f.c7.cnt", 32'(cnt), 32'd1);
    tick();

    // rst in cycle 3 of a 4-bit iteration
    m = '0; m[9] = 1'b1; m[8] = 1'b1; m[7] = 1'b1; m[6] = 1'b1;
    start(m, 1'b1);
    tick();
    check("g.c2.idx", 32'(o_idx), 32'd9);
    tick();
    check("g.c3.idx", 32'(o_idx), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("g.c4");
    tick();
    check("g.c5.done", 32'(done), 32'd0);
    check("g.c5.busy", 32'(busy), 32'd0);

    // all 288 bits: strict descending order, last flag on index 0 only
    exp_q.delete();
    for (int k = 287; k >= 0; k--) exp_q.push_back(9'(k));
    start('1, 1'b1);
    tick();
    for (int k = 0; k < 288; k++) begin
      check("h.valid", 32'(o_valid), 32'd1);
      check("h.idx", 32'(o_idx), 32'(exp_q.pop_front()));
      check("h.last", 32'(o_last), (k == 287) ? 32'd1 : 32'd0);
      tick();
    end
    check("h.done", 32'(done), 32'd1);
    check("h.cnt", 32'(cnt), 32'd288);
    check("h.valid_end", 32'(o_valid), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
